frv_mem_responder: RTL and testbench

FRV_MEM_RESPONDER -- requirements
Module: frv_mem_responder

---
 rtl/frv_mem_responder.sv | 112 +++++++++++
 tb/tb_frv_mem_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frv_mem_responder.sv
// Word-addressed memory slave with byte strobes and an in-order response FIFO.
// Optional range checking is enabled by defining FRV_MEM_RANGE_CHECK_EN.
module frv_mem_responder #(
  parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          RSP_DEPTH = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic        mem_gnt,
  output logic        mem_recv,
  input  logic        mem_ack,
  output logic        mem_error,
  output logic [31:0] mem_rdata
);

  localparam int             AW    = $clog2(MEM_WORDS);
  localparam int             PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [2:0]     DEPTH = 3'(RSP_DEPTH);
  localparam logic [PW-1:0]  LAST  = PW'(RSP_DEPTH - 1);

  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   fifo_rdata [RSP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    inflight;

  logic [31:0]   offset;
  logic [29:0]   idx_full;
  logic [AW-1:0] idx;
  logic          out_of_range;
  logic          accept;
  logic          pop;
  logic          do_write;
  logic [31:0]   rsp_rdata;
  logic          unused_bits;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign offset   = mem_addr - MEM_BASE;
  assign idx_full = offset[31:2];
  assign idx      = idx_full[AW-1:0];

`ifdef FRV_MEM_RANGE_CHECK_EN
  // Addresses below MEM_BASE wrap to huge indices and are caught here too.
  assign out_of_range = (idx_full >= 30'(MEM_WORDS));
`else
  assign out_of_range = 1'b0;
`endif

  assign unused_bits = ^{offset[1:0], idx_full};

  // The reset term blocks both the write and the FIFO push in a reset cycle.
  assign accept   = mem_req && mem_gnt && g_resetn;
  assign pop      = mem_recv && mem_ack;
  assign do_write = accept && mem_wen && !out_of_range;

  // The array read here sees every write from earlier cycles.
  assign rsp_rdata = (mem_wen || out_of_range) ? 32'd0 : mem[idx];

  assign mem_gnt   = (inflight < DEPTH);
  assign mem_recv  = (inflight != 3'd0);
  assign mem_rdata = mem_recv ? fifo_rdata[rd_ptr] : 32'd0;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      inflight <= 3'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (accept) wr_ptr <= next_ptr(wr_ptr);
      if (pop)    rd_ptr <= next_ptr(rd_ptr);
      case ({accept, pop})
        2'b10:   inflight <= inflight + 3'd1;
        2'b01:   inflight <= inflight - 3'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (accept) fifo_rdata[wr_ptr] <= rsp_rdata;
  end

  always_ff @(posedge g_clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_strb[b]) mem[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

`ifdef FRV_MEM_RANGE_CHECK_EN
  logic fifo_error [RSP_DEPTH];

  always_ff @(posedge g_clk) begin
    if (accept) fifo_error[wr_ptr] <= out_of_range;
  end

  assign mem_error = mem_recv && fifo_error[rd_ptr];
`else
  assign mem_error = 1'b0;
`endif

endmodule

// File: tb/tb_frv_mem_responder.sv
// Scoreboard bench for frv_mem_responder: random and directed traffic against
// a word-array reference model; builds with or without FRV_MEM_RANGE_CHECK_EN.
module tb_frv_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 1024;
  localparam int          DEPTH = 2;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_wen = 1'b0;
  logic [3:0]  mem_strb = 4'h0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_addr = 32'd0;
  logic        mem_ack = 1'b0;
  logic        mem_gnt;
  logic        mem_recv;
  logic        mem_error;
  logic [31:0] mem_rdata;

  always #5 g_clk = ~g_clk;

  frv_mem_responder #(
    .MEM_BASE (BASE),
    .MEM_WORDS(WORDS),
    .RSP_DEPTH(DEPTH)
  ) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .mem_req  (mem_req),
    .mem_wen  (mem_wen),
    .mem_strb (mem_strb),
    .mem_wdata(mem_wdata),
    .mem_addr (mem_addr),
    .mem_gnt  (mem_gnt),
    .mem_recv (mem_recv),
    .mem_ack  (mem_ack),
    .mem_error(mem_error),
    .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] model [WORDS];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ack_mode = 1;   // 0 random, 1 always, 2 never
  bit          chk_en = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  // Reference behaviour of one accepted request: memory as a plain word array.
  function automatic void model_accept(input logic [31:0] a, input logic w,
                                       input logic [3:0] s, input logic [31:0] d);
    logic [31:0] off;
    int          widx;
    rsp_t        r;
    off = a - BASE;
`ifdef FRV_MEM_RANGE_CHECK_EN
    if ((off >> 2) >= 32'(WORDS)) begin
      r.rdata = 32'd0;
      r.error = 1'b1;
      exp_q.push_back(r);
      return;
    end
`endif
    widx = int'((off >> 2) % 32'(WORDS));
    r.error = 1'b0;
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[widx][8*b +: 8] = d[8*b +: 8];
      r.rdata = 32'd0;
    end else begin
      r.rdata = model[widx];
    end
    exp_q.push_back(r);
  endfunction

  // Response monitor: drives ack, pops the scoreboard on each handshake.
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = 32'd0;
  logic        hold_e = 1'b0;

  always @(negedge g_clk) begin : mon
    rsp_t e;
    case (ack_mode)
      0:       mem_ack = 1'($urandom_range(0, 1));
      1:       mem_ack = 1'b1;
      default: mem_ack = 1'b0;
    endcase
    if (chk_en && hold_v && mem_recv) begin
      check("hold_rdata", mem_rdata, hold_d);
      check("hold_error", {31'b0, mem_error}, {31'b0, hold_e});
    end
    hold_v = mem_recv && !mem_ack;
    hold_d = mem_rdata;
    hold_e = mem_error;
    if (mem_recv && mem_ack) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rdata %h, expected no response", mem_rdata);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", mem_rdata, e.rdata);
        check("rsp_error", {31'b0, mem_error}, {31'b0, e.error});
      end
    end
  end

  // Outstanding-count view: grant and recv follow the number of pending responses.
  always @(posedge g_clk) begin
    #1;
    if (chk_en) begin
      check("gnt_vs_pending", {31'b0, mem_gnt}, {31'b0, exp_q.size() < DEPTH});
      check("recv_vs_pending", {31'b0, mem_recv}, {31'b0, exp_q.size() != 0});
    end
  end

  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input int max_cyc, output bit ok);
    ok = 1'b0;
    @(negedge g_clk);
    mem_req = 1'b1; mem_addr = a; mem_wen = w; mem_strb = s; mem_wdata = d;
    for (int i = 0; i < max_cyc; i++) begin
      if (mem_gnt) begin
        model_accept(a, w, s, d);
        ok = 1'b1;
        break;
      end
      @(negedge g_clk);
    end
    if (ok) begin
      @(posedge g_clk);
      #1;
    end
    mem_req = 1'b0;
  endtask

  task automatic req_chk(input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d, input string name);
    bit ok;
    issue(a, w, s, d, 40, ok);
    check(name, {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_drain();
    int i;
    ack_mode = 1;
    for (i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge g_clk);
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    bit          ok;
    logic [31:0] a;
    int          k;
    int          sel;

    g_resetn = 1'b0;
    repeat (3) @(negedge g_clk);
    check("rst_recv", {31'b0, mem_recv}, 32'd0);
    check("rst_error", {31'b0, mem_error}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    g_resetn = 1'b1;
    @(negedge g_clk);
    check("rst_gnt", {31'b0, mem_gnt}, 32'd1);
    chk_en = 1'b1;
    ack_mode = 1;

    for (int i = 0; i < 16; i++)
      req_chk(BASE + 32'(4*i), 1'b1, 4'hF, $urandom, "init_grant");

    // Back-to-back write then read of word 0
    req_chk(BASE, 1'b1, 4'hF, 32'h1122_3344, "b2b_wr_grant");
    req_chk(BASE, 1'b0, 4'h0, 32'd0, "b2b_rd_grant");
    check("b2b_recv", {31'b0, mem_recv}, 32'd1);
    check("b2b_rdata", mem_rdata, 32'h1122_3344);

    // Byte strobes
    req_chk(BASE + 32'd8, 1'b1, 4'hF, 32'hAABB_CCDD, "strb_wr0");
    req_chk(BASE + 32'd8, 1'b1, 4'b0101, 32'h0011_0022, "strb_wr1");
    req_chk(BASE + 32'd8, 1'b0, 4'h0, 32'd0, "strb_rd");
    check("strb_rdata", mem_rdata, 32'hAA11_CC22);

    // One word past the end of the array
    req_chk(BASE + 32'h1000, 1'b0, 4'h0, 32'd0, "range_grant");
`ifdef FRV_MEM_RANGE_CHECK_EN
    check("range_error", {31'b0, mem_error}, 32'd1);
    check("range_rdata", mem_rdata, 32'd0);
`else
    check("range_error", {31'b0, mem_error}, 32'd0);
    check("range_rdata", mem_rdata, 32'h1122_3344);
`endif
    wait_drain();

    // Backpressure: only DEPTH requests get through while ack is held low
    ack_mode = 2;
    req_chk(BASE + 32'd4, 1'b0, 4'h0, 32'd0, "bp_grant0");
    req_chk(BASE + 32'd8, 1'b0, 4'h0, 32'd0, "bp_grant1");
    issue(BASE + 32'd12, 1'b0, 4'h0, 32'd0, 6, ok);
    check("bp_third_blocked", {31'b0, ok}, 32'd0);
    ack_mode = 1;
    req_chk(BASE + 32'd12, 1'b0, 4'h0, 32'd0, "bp_resume");
    wait_drain();

    // Full FIFO with a pop and a pending request in the same cycle
    ack_mode = 2;
    req_chk(BASE + 32'd16, 1'b1, 4'hF, 32'h5A5A_0001, "full_grant0");
    req_chk(BASE + 32'd16, 1'b0, 4'h0, 32'd0, "full_grant1");
    ack_mode = 1;
    req_chk(BASE + 32'd20, 1'b0, 4'h0, 32'd0, "full_grant2");
    wait_drain();

    // Random traffic over 16 words, including aliases outside the array
    ack_mode = 0;
    repeat (300) begin
      k   = int'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 7));
      a   = BASE + 32'(4*k) + 32'($urandom_range(0, 3));
      if (sel == 0) a = BASE + 32'h1000 + 32'(4*k);
      if (sel == 1) a = BASE - 32'h1000 + 32'(4*k);
      req_chk(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, "rand_grant");
    end
    wait_drain();

    // Reset with two responses outstanding
    ack_mode = 2;
    req_chk(BASE + 32'd12, 1'b0, 4'h0, 32'd0, "mid_grant0");
    req_chk(BASE + 32'd16, 1'b0, 4'h0, 32'd0, "mid_grant1");
    @(negedge g_clk);
    g_resetn = 1'b0;
    exp_q.delete();
    @(negedge g_clk);
    g_resetn = 1'b1;
    check("mid_rst_recv", {31'b0, mem_recv}, 32'd0);
    check("mid_rst_gnt", {31'b0, mem_gnt}, 32'd1);
    ack_mode = 1;
    repeat (5) @(negedge g_clk);

    // A write presented during reset must not land
    g_resetn = 1'b0;
    mem_req = 1'b1; mem_wen = 1'b1; mem_strb = 4'hF;
    mem_addr = BASE + 32'd12; mem_wdata = ~model[3];
    @(negedge g_clk);
    g_resetn = 1'b1;
    mem_req = 1'b0;
    req_chk(BASE + 32'd12, 1'b0, 4'h0, 32'd0, "post_rst_rd");
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
